// File: rtl/ub_readout.sv
// ub_readout: drains a contiguous range of unified-buffer words to a
// valid/ready stream. Reads are issued only against free credit in a 2-entry
// skid FIFO. A returning word that meets an empty FIFO is presented straight
// off ub_rd_data, so the stream runs one word per cycle with no extra stage.
module ub_readout #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ub_rd_en,
  output logic [ADDR_W-1:0] ub_rd_addr,
  input  logic [DATA_W-1:0] ub_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          issue_left_q, issue_left_d;
  logic [ADDR_W:0]          out_left_q, out_left_d;
  logic                     inflight_q, inflight_d;
  logic [1:0][DATA_W-1:0]   fifo_q, fifo_d;
  logic                     wr_idx_q, wr_idx_d;
  logic                     rd_idx_q, rd_idx_d;
  logic [1:0]               count_q, count_d;

  logic                     pop;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [2:0]               occupancy;
  logic [ADDR_W:0]          length_clamped;

  // Handshake and the FIFO's view of it; a bypassed word never enters storage.
  assign pop       = out_valid && out_ready;
  assign fifo_pop  = pop && (count_q != 2'd0);
  assign fifo_push = inflight_q && !((count_q == 2'd0) && pop);
  assign occupancy = 3'(count_q) + 3'(inflight_q);
  assign length_clamped = (length > DEPTH_L) ? DEPTH_L : length;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_READ;
      S_READ:  if (ub_rd_en && (issue_left_q == (ADDR_W+1)'(1))) state_d = S_DRAIN;
      S_DRAIN: if (pop && (out_left_q == (ADDR_W+1)'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: read issue against credit, and the stream head.
  always_comb begin
    busy       = (state_q == S_READ) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    ub_rd_en   = (state_q == S_READ) && (issue_left_q != '0)
                 && (occupancy < (3'd2 + 3'(pop)));
    ub_rd_addr = rd_ptr_q;
    out_valid  = (count_q != 2'd0) || inflight_q;
    out_data   = ((count_q == 2'd0) && inflight_q) ? ub_rd_data : fifo_q[rd_idx_q];
    out_last   = out_valid && (out_left_q == (ADDR_W+1)'(1));
  end

  // Datapath next values: counters, read pointer and skid FIFO.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = ub_rd_en;
    fifo_d       = fifo_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;

    if ((state_q == S_IDLE) && start && (length != '0)) begin
      rd_ptr_d     = start_addr;
      issue_left_d = length_clamped;
      out_left_d   = length_clamped;
    end
    if (ub_rd_en) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      issue_left_d = issue_left_q - 1'b1;
    end
    if (pop) out_left_d = out_left_q - 1'b1;

    if (fifo_push) begin
      fifo_d[wr_idx_q] = ub_rd_data;
      wr_idx_d         = ~wr_idx_q;
    end
    if (fifo_pop) rd_idx_d = ~rd_idx_q;
    count_d = count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
  end

  // Datapath registers.
  // NOTE: the two FIFO entries are reset too, because the head drives out_data
  // and must read 0 while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_q       <= '0;
      wr_idx_q     <= 1'b0;
      rd_idx_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      fifo_q       <= fifo_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_ub_readout.sv
// Directed bench for ub_readout: a synchronous-read memory model holding
// mem[i] = i + 6, a negedge monitor that logs reads, handshakes and done
// pulses, and one linear sequence of checked steps.
module tb_ub_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  length;
  logic        busy, done, ub_rd_en, out_valid, out_ready, out_last;
  logic [5:0]  ub_rd_addr;
  logic [31:0] ub_rd_data = '0;
  logic [31:0] out_data;

  logic [31:0] mem [64];
  logic [31:0] rx_q[$];
  logic        rx_last_q[$];
  logic [5:0]  rd_q[$];
  int          done_cnt;
  int          nvec = 0;
  int          nerr = 0;
  int          last_cnt;

  ub_readout #(.DATA_W(32), .DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ub_rd_en   (ub_rd_en),
    .ub_rd_addr (ub_rd_addr),
    .ub_rd_data (ub_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Unified buffer: data valid the cycle after the read strobe.
  always @(posedge clk) if (ub_rd_en) ub_rd_data <= mem[ub_rd_addr];

  // Observation half a cycle before each edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rx_q.push_back(out_data);
      rx_last_q.push_back(out_last);
    end
    if (ub_rd_en) rd_q.push_back(ub_rd_addr);
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_last_q.delete();
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_xfer(input logic [5:0] a, input logic [6:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    next_cyc();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      next_cyc();
    end
    check(tag, done, 1'b1);
    next_cyc();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 6);
    done_cnt = 0;

    // Reset held with random inputs: every output reads 0.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom_range(0, 1));
      start_addr = 6'($urandom_range(0, 63));
      length     = 7'($urandom_range(0, 127));
      out_ready  = 1'($urandom_range(0, 1));
      #7;
      check("rst_ctrl", {busy, done, ub_rd_en, out_valid, out_last}, 5'b0);
      check("rst_addr", ub_rd_addr, 6'd0);
      check("rst_data", out_data, 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    next_cyc();
    reset = 1'b1;
    next_cyc();
    next_cyc();
    check("idle_busy", busy, 1'b0);
    check("idle_valid", out_valid, 1'b0);

    // Basic: 4 words from address 4, sink always ready.
    clear_logs();
    start_xfer(6'd4, 7'd4);
    check("basic_busy", busy, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("basic_rd_en", ub_rd_en, (k < 4));
      if (k < 4) check("basic_rd_addr", ub_rd_addr, 32'(4 + k));
      check("basic_valid", out_valid, (k >= 1));
      if (k >= 1) begin
        check("basic_data", out_data, 32'(10 + k - 1));
        check("basic_last", out_last, (k == 4));
      end
      next_cyc();
    end
    check("basic_done", done, 1'b1);
    check("basic_busy_end", busy, 1'b0);
    next_cyc();
    check("basic_done_pulse", done, 1'b0);
    check("basic_count", rx_q.size(), 4);
    check("basic_done_cnt", done_cnt, 1);

    // Back-pressure: sink stalled for 8 cycles after start.
    clear_logs();
    out_ready = 1'b0;
    start_xfer(6'd4, 7'd4);
    for (int k = 1; k <= 8; k++) begin
      if (k >= 2) begin
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_data", out_data, 32'd10);
      end
      next_cyc();
    end
    check("bp_reads_stalled", rd_q.size(), 2);
    out_ready = 1'b1;
    #1;
    check("bp_resume_rd_en", ub_rd_en, 1'b1);
    wait_done("bp_done_seen", 20);
    check("bp_count", rx_q.size(), 4);
    for (int i = 0; i < rx_q.size(); i++) check("bp_data", rx_q[i], 32'(10 + i));
    check("bp_done_cnt", done_cnt, 1);

    // Address wrap: 62, 63, 0, 1.
    clear_logs();
    start_xfer(6'd62, 7'd4);
    wait_done("wrap_done_seen", 20);
    check("wrap_rd_count", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      check("wrap_addr0", rd_q[0], 6'd62);
      check("wrap_addr1", rd_q[1], 6'd63);
      check("wrap_addr2", rd_q[2], 6'd0);
      check("wrap_addr3", rd_q[3], 6'd1);
    end
    check("wrap_count", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      check("wrap_data0", rx_q[0], 32'd68);
      check("wrap_data1", rx_q[1], 32'd69);
      check("wrap_data2", rx_q[2], 32'd6);
      check("wrap_data3", rx_q[3], 32'd7);
    end

    // Zero length: done in the first cycle, no reads.
    clear_logs();
    start_xfer(6'd5, 7'd0);
    check("len0_done", done, 1'b1);
    check("len0_rd_en", ub_rd_en, 1'b0);
    check("len0_busy", busy, 1'b0);
    next_cyc();
    check("len0_done_pulse", done, 1'b0);
    check("len0_reads", rd_q.size(), 0);

    // Oversized length clamps to 64 words.
    clear_logs();
    start_xfer(6'd0, 7'd100);
    wait_done("clamp_done_seen", 200);
    check("clamp_count", rx_q.size(), 64);
    check("clamp_reads", rd_q.size(), 64);
    last_cnt = 0;
    foreach (rx_last_q[i]) if (rx_last_q[i]) last_cnt++;
    check("clamp_last_cnt", last_cnt, 1);
    if (rx_q.size() == 64) begin
      check("clamp_last_flag", rx_last_q[63], 1'b1);
      check("clamp_last_data", rx_q[63], 32'd69);
    end

    // Start pulsed while busy is ignored.
    clear_logs();
    start_xfer(6'd4, 7'd4);
    start_xfer(6'd0, 7'd8);
    wait_done("busy_start_done_seen", 20);
    check("busy_start_count", rx_q.size(), 4);
    if (rx_q.size() == 4) check("busy_start_tail", rx_q[3], 32'd13);
    next_cyc();
    check("busy_start_idle", busy, 1'b0);

    // Reset after 2 of 8 words delivered.
    clear_logs();
    start_xfer(6'd0, 7'd8);
    for (int i = 0; i < 10 && rx_q.size() < 2; i++) next_cyc();
    check("mid_two_words", rx_q.size(), 2);
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {busy, done, ub_rd_en, out_valid, out_last}, 5'b0);
    check("mid_rst_addr", ub_rd_addr, 6'd0);
    check("mid_rst_data", out_data, 32'd0);
    next_cyc();
    next_cyc();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) next_cyc();
    check("mid_no_done", done_cnt, 0);
    check("mid_idle", busy, 1'b0);
    clear_logs();
    start_xfer(6'd0, 7'd2);
    wait_done("post_rst_done_seen", 20);
    check("post_rst_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("post_rst_data0", rx_q[0], 32'd6);
      check("post_rst_data1", rx_q[1], 32'd7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
